n64_flashram_engine: RTL and testbench
======================================

// Module: n64_flashram_engine
// PURPOSE
// - Memory-side executor for FlashRAM save emulation: services erase/program requests raised by the N64 FlashRAM front end.
// - Captures the 128-byte page buffer, then on request streams it (program) or 0xFFFF (erase) into SDRAM via a single-word memory master.
// - Sits between the N64 SCB FlashRAM signals and the SDRAM arbiter port; pulses done to clear the front end's pending/busy status.
// PARAMETERS
// - MEM_ADDR_W   26            byte-address width of memory port
// - FLASH_BASE   26'h3FE_0000  byte address of FlashRAM image (128 KiB aligned)
// PORTS
// - clk               in   1   system clock
// - reset             in   1   asynchronous, active-high reset
// - buf_write         in   1   N64 write into page buffer (one 16-bit word)
// - buf_address       in   6   buffer word index 0..63
// - buf_wdata         in   16  buffer write data
// - pending           in   1   request outstanding (level, held by front end until after done)
// - write_or_erase    in   1   0 = program page, 1 = erase
// - sector_or_all     in   1   erase scope: 0 = sector, 1 = whole chip
// - page              in   10  target page (program) / any page inside sector (erase)
// - done              out  1   one-cycle pulse when operation complete
// - busy              out  1   high from request accept until done
// - mem_request       out  1   memory write request
// - mem_ack           in   1   memory accepted current word
// - mem_address       out  MEM_ADDR_W  byte address, bit0 always 0
// - mem_wdata         out  16  write data
// BEHAVIOUR
// - Reset (async): state IDLE; done, busy, mem_request = 0; mem_address = FLASH_BASE; mem_wdata = 0; counter = 0. Buffer contents not reset.
// - Geometry: page = 64 words/128 B; sector = 128 pages (16 KiB, 8192 words); chip = 1024 pages (128 KiB, 65536 words).
// - Start address: program -> FLASH_BASE + {page,7'd0}; sector erase -> FLASH_BASE + {page[9:7],14'd0}; chip erase -> FLASH_BASE.
// - Word count N: program 64, sector 8192, chip 65536; 17-bit counter, terminal when count == N-1 acked.
// - Buffer: 64x16, write port from buf_*; writes accepted only in IDLE, dropped while busy. Read port registered, 1-cycle latency.
// - FSM: IDLE -> (pending) latch mode/page, busy=1 -> FETCH if program, REQUEST if erase.
//   FETCH: present buffer read addr = counter[5:0]; next cycle load mem_wdata -> REQUEST.
//   REQUEST: mem_request=1, address/wdata stable until mem_ack sampled high; on ack: if last -> DONE,
//   else counter+1, address+2, -> FETCH (program) or stay REQUEST with new address (erase, wdata 16'hFFFF).
//   Request may deassert for at most the FETCH cycle; never asserted without valid data.
//   DONE: done=1 for exactly one cycle, busy=0 -> WAIT_CLEAR.
//   WAIT_CLEAR: stay until pending==0, then IDLE (prevents re-triggering on the stale pending level).
// - Program copies verbatim (no AND with old contents). Address wraps never occur: ranges stay inside the 128 KiB image.
// - write_or_erase, sector_or_all, page sampled only at IDLE->start; later changes ignored.
// - mem_ack outside REQUEST ignored. Reset mid-operation aborts immediately: mem_request drops, no done pulse.
// STRUCTURE
// - Shared package n64_flashram_pkg: FLASH_PAGE_WORDS=64, FLASH_SECTOR_PAGES=128, FLASH_PAGES=1024, erase fill 16'hFFFF.
// - FSM enum local to module.
// - Sub-module n64_flashram_buffer: 64x16 simple dual-port RAM, registered read (infers block RAM).
// TESTING
// - Fill buffer words i=0..63 with 16'h1000+i, pending, write_or_erase=0, page=5 -> 64 writes at FLASH_BASE+0x280+2i, data 16'h1000+i, one done.
// - Sector erase page=0x085 -> 8192 writes of 16'hFFFF from FLASH_BASE+0x4000 to +0x7FFE, then done.
// - Chip erase -> 65536 writes of 16'hFFFF covering FLASH_BASE..FLASH_BASE+0x1FFFE, exactly one done.
// - Random mem_ack delays 0..7 cycles -> address/wdata stable while request high, no word skipped or duplicated.
// - Hold pending 3 cycles after done -> no second operation; buf_write during busy -> buffer unchanged.
// - Assert reset at word 20 of a program -> mem_request=0, busy=0 same edge, no done; fresh request afterwards completes normally.

Source files
------------

// File: rtl/n64_flashram_pkg.sv
// n64_flashram_pkg
//   FlashRAM image geometry shared by the save-emulation blocks: page,
//   sector and chip sizes in words, the value erased cells read back as,
//   and the terminal word index for each kind of operation.
package n64_flashram_pkg;

   localparam int FLASH_PAGE_WORDS   = 64;
   localparam int FLASH_SECTOR_PAGES = 128;
   localparam int FLASH_PAGES        = 1024;

   localparam logic [15:0] FLASH_ERASE_FILL = 16'hFFFF;

   localparam logic [16:0] LAST_WORD_PAGE   = 17'(FLASH_PAGE_WORDS - 1);
   localparam logic [16:0] LAST_WORD_SECTOR = 17'(FLASH_SECTOR_PAGES * FLASH_PAGE_WORDS - 1);
   localparam logic [16:0] LAST_WORD_CHIP   = 17'(FLASH_PAGES * FLASH_PAGE_WORDS - 1);

   // Index of the final word written by an operation (word count minus one).
   function automatic logic [16:0] last_word_index(input logic is_erase,
                                                   input logic whole_chip);
      if (!is_erase)
         return LAST_WORD_PAGE;
      else if (!whole_chip)
         return LAST_WORD_SECTOR;
      else
         return LAST_WORD_CHIP;
   endfunction

endpackage

// File: rtl/n64_flashram_buffer.sv
// n64_flashram_buffer
//   64 x 16 FlashRAM page buffer. Simple dual-port: one write port from the
//   N64 side, one read port with a registered output (1-cycle latency) so it
//   maps onto block RAM. Contents are not reset.
// Ports
//   clk      system clock
//   wr_en    write strobe
//   wr_addr  write word index
//   wr_data  write data
//   rd_addr  read word index, sampled every cycle
//   rd_data  word at rd_addr from the previous cycle
module n64_flashram_buffer
   import n64_flashram_pkg::*;
(
   input  logic        clk,
   input  logic        wr_en,
   input  logic [5:0]  wr_addr,
   input  logic [15:0] wr_data,
   input  logic [5:0]  rd_addr,
   output logic [15:0] rd_data
);

   logic [15:0] mem_q [FLASH_PAGE_WORDS];
   logic [15:0] rd_data_q;

   always_ff @(posedge clk) begin
      if (wr_en)
         mem_q[wr_addr] <= wr_data;
      rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/n64_flashram_engine.sv
// n64_flashram_engine
//   Memory-side executor for FlashRAM save emulation. Holds the 128-byte
//   page buffer and, when the front end raises pending, writes either the
//   buffer (program) or 0xFFFF (sector / chip erase) into the FlashRAM image
//   in SDRAM one 16-bit word at a time, then pulses done.
// Ports
//   clk, reset                    clock, async active-high reset
//   buf_write/address/wdata       N64 writes into the page buffer
//   pending, write_or_erase,      request level and its mode/target,
//   sector_or_all, page           sampled only when the request is accepted
//   done, busy                    completion pulse / operation in progress
//   mem_request, mem_ack,         single-word memory write master
//   mem_address, mem_wdata
//
// state      | meaning
// -----------+-----------------------------------------------------------
// IDLE       | waiting for pending; buffer writes accepted here only
// FETCH      | buffer word for counter is on rd_data; load it into wdata
// REQUEST    | mem_request high, address/data held until mem_ack
// DONE       | done pulse, busy already low
// WAIT_CLEAR | wait for the front end to drop the stale pending level
module n64_flashram_engine
   import n64_flashram_pkg::*;
#(
   parameter int                    MEM_ADDR_W = 26,
   parameter logic [MEM_ADDR_W-1:0] FLASH_BASE = 26'h3FE_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  buf_write,
   input  logic [5:0]            buf_address,
   input  logic [15:0]           buf_wdata,
   input  logic                  pending,
   input  logic                  write_or_erase,
   input  logic                  sector_or_all,
   input  logic [9:0]            page,
   output logic                  done,
   output logic                  busy,
   output logic                  mem_request,
   input  logic                  mem_ack,
   output logic [MEM_ADDR_W-1:0] mem_address,
   output logic [15:0]           mem_wdata
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_REQUEST,
      S_DONE,
      S_WAIT_CLEAR
   } state_e;

   state_e                state_q, state_d;
   logic                  is_erase_q, is_erase_d;
   logic [16:0]           last_q, last_d;
   logic [16:0]           counter_q, counter_d;
   logic                  done_q, done_d;
   logic                  busy_q, busy_d;
   logic                  mem_request_q, mem_request_d;
   logic [MEM_ADDR_W-1:0] mem_address_q, mem_address_d;
   logic [15:0]           mem_wdata_q, mem_wdata_d;

   logic [16:0]           start_offset;
   logic [5:0]            rd_addr;
   logic [15:0]           rd_data;

   n64_flashram_buffer u_buffer (
      .clk     (clk),
      .wr_en   (buf_write && (state_q == S_IDLE)),
      .wr_addr (buf_address),
      .wr_data (buf_wdata),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   always_comb begin
      if (!write_or_erase)
         start_offset = {page, 7'd0};
      else if (!sector_or_all)
         start_offset = {page[9:7], 14'd0};
      else
         start_offset = '0;
   end

   always_comb begin
      state_d       = state_q;
      is_erase_d    = is_erase_q;
      last_d        = last_q;
      counter_d     = counter_q;
      done_d        = 1'b0;
      busy_d        = busy_q;
      mem_request_d = mem_request_q;
      mem_address_d = mem_address_q;
      mem_wdata_d   = mem_wdata_q;

      case (state_q)
         S_IDLE: begin
            if (pending) begin
               is_erase_d    = write_or_erase;
               last_d        = last_word_index(write_or_erase, sector_or_all);
               counter_d     = '0;
               mem_address_d = FLASH_BASE + MEM_ADDR_W'(start_offset);
               busy_d        = 1'b1;
               if (write_or_erase) begin
                  mem_wdata_d   = FLASH_ERASE_FILL;
                  mem_request_d = 1'b1;
                  state_d       = S_REQUEST;
               end else begin
                  state_d       = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            mem_wdata_d   = rd_data;
            mem_request_d = 1'b1;
            state_d       = S_REQUEST;
         end
         S_REQUEST: begin
            if (mem_ack) begin
               if (counter_q == last_q) begin
                  mem_request_d = 1'b0;
                  done_d        = 1'b1;
                  busy_d        = 1'b0;
                  state_d       = S_DONE;
               end else begin
                  counter_d     = counter_q + 17'd1;
                  mem_address_d = mem_address_q + MEM_ADDR_W'(2);
                  if (!is_erase_q) begin
                     mem_request_d = 1'b0;
                     state_d       = S_FETCH;
                  end
               end
            end
         end
         S_DONE: begin
            state_d = S_WAIT_CLEAR;
         end
         S_WAIT_CLEAR: begin
            if (!pending)
               state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Read address tracks the next counter value, so the word needed in
      // FETCH is already on rd_data and request drops for a single cycle.
      rd_addr = counter_d[5:0];
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= S_IDLE;
         is_erase_q    <= 1'b0;
         last_q        <= '0;
         counter_q     <= '0;
         done_q        <= 1'b0;
         busy_q        <= 1'b0;
         mem_request_q <= 1'b0;
         mem_address_q <= FLASH_BASE;
         mem_wdata_q   <= '0;
      end else begin
         state_q       <= state_d;
         is_erase_q    <= is_erase_d;
         last_q        <= last_d;
         counter_q     <= counter_d;
         done_q        <= done_d;
         busy_q        <= busy_d;
         mem_request_q <= mem_request_d;
         mem_address_q <= mem_address_d;
         mem_wdata_q   <= mem_wdata_d;
      end
   end

   assign done        = done_q;
   assign busy        = busy_q;
   assign mem_request = mem_request_q;
   assign mem_address = mem_address_q;
   assign mem_wdata   = mem_wdata_q;

endmodule

// File: tb/tb_n64_flashram_engine.sv
// tb_n64_flashram_engine
//   Directed bench for the FlashRAM engine: program, sector erase, chip
//   erase, retrigger guard, dropped buffer writes while busy, and reset in
//   the middle of a program. Expected memory writes are queued when an
//   operation is started and popped as the memory side accepts each word.
module tb_n64_flashram_engine;

   localparam logic [25:0] BASE = 26'h3FE_0000;

   logic        clk = 1'b0;
   logic        reset;
   logic        buf_write;
   logic [5:0]  buf_address;
   logic [15:0] buf_wdata;
   logic        pending;
   logic        write_or_erase;
   logic        sector_or_all;
   logic [9:0]  page;
   logic        done;
   logic        busy;
   logic        mem_request;
   logic        mem_ack = 1'b0;
   logic [25:0] mem_address;
   logic [15:0] mem_wdata;

   typedef struct packed {
      logic [25:0] addr;
      logic [15:0] data;
   } xfer_t;

   xfer_t       exp_q[$];
   int          tests = 0;
   int          fails = 0;
   int          xfer_cnt = 0;
   int          done_cnt = 0;
   int          wait_cnt = 0;
   bit          fast_ack = 1'b0;
   bit          hold_valid = 1'b0;
   logic [25:0] hold_addr;
   logic [15:0] hold_data;

   n64_flashram_engine dut (
      .clk            (clk),
      .reset          (reset),
      .buf_write      (buf_write),
      .buf_address    (buf_address),
      .buf_wdata      (buf_wdata),
      .pending        (pending),
      .write_or_erase (write_or_erase),
      .sector_or_all  (sector_or_all),
      .page           (page),
      .done           (done),
      .busy           (busy),
      .mem_request    (mem_request),
      .mem_ack        (mem_ack),
      .mem_address    (mem_address),
      .mem_wdata      (mem_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Memory responder and scoreboard. Decides mem_ack on the falling edge;
   // a word is accepted on the next rising edge when request and ack are high.
   always @(negedge clk) begin
      if (done === 1'b1)
         done_cnt++;
      if (mem_request === 1'b1) begin
         if (hold_valid) begin
            chk("addr_stable", 32'(mem_address), 32'(hold_addr));
            chk("data_stable", 32'(mem_wdata), 32'(hold_data));
         end
         if (fast_ack || wait_cnt == 0) begin
            xfer_t e;
            mem_ack    = 1'b1;
            hold_valid = 1'b0;
            xfer_cnt++;
            chk("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
               e = exp_q.pop_front();
               chk("write_addr", 32'(mem_address), 32'(e.addr));
               chk("write_data", 32'(mem_wdata), 32'(e.data));
            end
            wait_cnt = $urandom_range(0, 7);
         end else begin
            wait_cnt--;
            mem_ack    = 1'b0;
            hold_valid = 1'b1;
            hold_addr  = mem_address;
            hold_data  = mem_wdata;
         end
      end else begin
         hold_valid = 1'b0;
         mem_ack    = fast_ack ? 1'b0 : 1'($urandom_range(0, 1));
      end
   end

   task automatic push_program(input int pg);
      for (int i = 0; i < 64; i++) begin
         xfer_t e;
         e.addr = BASE + 26'(pg * 128 + 2 * i);
         e.data = 16'h1000 + 16'(i);
         exp_q.push_back(e);
      end
   endtask

   task automatic push_erase(input int offset, input int words);
      for (int i = 0; i < words; i++) begin
         xfer_t e;
         e.addr = BASE + 26'(offset + 2 * i);
         e.data = 16'hFFFF;
         exp_q.push_back(e);
      end
   endtask

   task automatic start_op(input logic we, input logic soa, input logic [9:0] pg);
      @(negedge clk);
      write_or_erase = we;
      sector_or_all  = soa;
      page           = pg;
      pending        = 1'b1;
   endtask

   task automatic wait_done(input int target, input int budget, input string tag);
      int n = 0;
      while (done_cnt < target && n < budget) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk(tag, 32'(done_cnt), 32'(target));
   endtask

   initial begin
      int x0;
      int n;
      reset          = 1'b1;
      buf_write      = 1'b0;
      buf_address    = '0;
      buf_wdata      = '0;
      pending        = 1'b0;
      write_or_erase = 1'b0;
      sector_or_all  = 1'b0;
      page           = '0;

      repeat (3) @(negedge clk);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_request", 32'(mem_request), 32'd0);
      chk("reset_address", 32'(mem_address), 32'(BASE));
      chk("reset_wdata", 32'(mem_wdata), 32'd0);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         buf_write   = 1'b1;
         buf_address = 6'(i);
         buf_wdata   = 16'h1000 + 16'(i);
      end
      @(negedge clk);
      buf_write = 1'b0;

      // Program page 5 with random ack latency; mode inputs change after
      // acceptance and buffer writes arrive while busy - both must be ignored.
      push_program(5);
      start_op(1'b0, 1'b0, 10'd5);
      @(negedge clk);
      write_or_erase = 1'b1;
      sector_or_all  = 1'b1;
      page           = 10'h3FF;
      @(negedge clk);
      chk("busy_during_program", 32'(busy), 32'd1);
      for (int i = 0; i < 4; i++) begin
         buf_write   = 1'b1;
         buf_address = 6'(i);
         buf_wdata   = 16'hDEAD;
         @(negedge clk);
      end
      buf_write = 1'b0;
      wait_done(1, 3000, "program5_done");
      chk("program5_all_words", 32'(exp_q.size()), 32'd0);

      // Pending stays high for three more cycles: no second operation.
      x0 = xfer_cnt;
      repeat (3) @(negedge clk);
      chk("hold_busy_low", 32'(busy), 32'd0);
      chk("hold_no_writes", 32'(xfer_cnt), 32'(x0));
      chk("hold_single_done", 32'(done_cnt), 32'd1);
      pending = 1'b0;

      // Sector erase: page 0x085 lies in sector 1.
      fast_ack = 1'b1;
      push_erase(32'h4000, 8192);
      start_op(1'b1, 1'b0, 10'h085);
      wait_done(2, 9000, "sector_erase_done");
      chk("sector_erase_all_words", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      pending = 1'b0;

      // Chip erase: page input is irrelevant.
      push_erase(0, 65536);
      start_op(1'b1, 1'b1, 10'h2AB);
      wait_done(3, 70000, "chip_erase_done");
      chk("chip_erase_all_words", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      pending  = 1'b0;
      fast_ack = 1'b0;

      // Reset during a program after 20 words.
      push_program(3);
      start_op(1'b0, 1'b0, 10'd3);
      x0 = xfer_cnt;
      n  = 0;
      while (xfer_cnt - x0 < 20 && n < 2000) begin
         @(posedge clk);
         #1;
         n++;
      end
      chk("reached_word_20", 32'(xfer_cnt - x0 >= 20), 32'd1);
      @(negedge clk);
      #2;
      reset = 1'b1;
      #1;
      chk("abort_request", 32'(mem_request), 32'd0);
      chk("abort_busy", 32'(busy), 32'd0);
      exp_q.delete();
      pending = 1'b0;
      repeat (3) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt), 32'd3);
      chk("abort_address", 32'(mem_address), 32'(BASE));
      reset = 1'b0;

      // Fresh program: buffer kept its contents through reset and never
      // took the writes made while busy.
      push_program(7);
      start_op(1'b0, 1'b0, 10'd7);
      wait_done(4, 3000, "program7_done");
      chk("program7_all_words", 32'(exp_q.size()), 32'd0);
      @(negedge clk);
      pending = 1'b0;
      repeat (3) @(negedge clk);
      chk("final_done_count", 32'(done_cnt), 32'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
